alu_sched: RTL and testbench

Round-robin scheduler that shares one multi-cycle ALU between `NREQ` requesters. Each requester offers a 10-bit operation word `{op[1:0], data2[3:0], data1[3:0]}` on a valid/ready handshake. The scheduler grants one requester at a time, issues the operation to the ALU, and counts the op-dependent latency itself. It returns the 9-bit result, tagged with the requester index, on a valid/ready response port. It sits between the input FIFOs and the ALU; the response port feeds the output FIFO.

---
 rtl/alu_sched_pkg.sv | 34 +++
 rtl/alu_sched_rr_pick.sv | 33 +++
 rtl/alu_sched.sv | 161 ++++++++++++++++
 tb/tb_alu_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Request word layout: {op[9:8], data2[7:4], data1[3:0]}.
package alu_sched_pkg;

    localparam int unsigned REQ_W  = 10;
    localparam int unsigned RES_W  = 9;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned OP_MSB = 9;
    localparam int unsigned D2_MSB = 7;
    localparam int unsigned D1_MSB = 3;

    typedef enum logic [OP_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Field order matches the request word bit layout (op at MSB).
    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] data1;
    } req_t;

endpackage

// File: rtl/alu_sched_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above
// rr_ptr_i, wrapping from NREQ-1 to 0.
// Ports: valid_i (request vector), rr_ptr_i (search start),
//        grant_o (one-hot), winner_o (index), any_valid_o.
module alu_sched_rr_pick #(
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_valid_o
);

    // Scan NREQ slots starting at rr_ptr_i; the first hit wins.
    always_comb begin
        int unsigned idx;
        grant_o     = '0;
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_i) + k) % NREQ;
            if (!any_valid_o && valid_i[idx]) begin
                any_valid_o  = 1'b1;
                winner_o     = IDX_W'(idx);
                grant_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one multi-cycle ALU among NREQ requesters.
// Ports: clk/reset (async active-high); req_valid/req_data/req_ready
//        (request handshake, 10-bit word per requester); alu_start,
//        alu_data1/2, alu_op, alu_result (ALU side); rsp_valid/rsp_ready/
//        rsp_result/rsp_id/rsp_err (response handshake); busy.
// Optional: define ALU_SCHED_DIV0_EN to short-circuit div-by-zero with
//        result 9'h1FF and rsp_err=1; otherwise rsp_err is tied 0.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter  int unsigned NREQ          = 4,
    parameter  int unsigned MULDIV_CYCLES = 3,
    localparam int unsigned IDX_W         = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*REQ_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  alu_start,
    output logic [DATA_W-1:0]     alu_data1,
    output logic [DATA_W-1:0]     alu_data2,
    output logic [OP_W-1:0]       alu_op,
    input  logic [RES_W-1:0]      alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RES_W-1:0]      rsp_result,
    output logic [IDX_W-1:0]      rsp_id,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned LAT_W = (MULDIV_CYCLES < 2) ? 1 : $clog2(MULDIV_CYCLES + 1);

    state_e             state_q, state_d;
    req_t               op_q, op_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [RES_W-1:0]   result_q, result_d;
`ifdef ALU_SCHED_DIV0_EN
    logic               err_q, err_d;
`endif

    logic [NREQ-1:0]    grant;
    logic [IDX_W-1:0]   winner;
    logic               any_valid;
    req_t               sel_req;

    alu_sched_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i     (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    // Operation word of the current round-robin winner.
    always_comb begin
        sel_req = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (winner == IDX_W'(k)) begin
                sel_req = req_t'(req_data[k*REQ_W +: REQ_W]);
            end
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        id_d      = id_q;
        rr_ptr_d  = rr_ptr_q;
        lat_cnt_d = lat_cnt_q;
        result_d  = result_q;
`ifdef ALU_SCHED_DIV0_EN
        err_d     = err_q;
`endif
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                // Grant is suppressed while reset is held so req_ready reads 0.
                if (any_valid && !reset) begin
                    req_ready = grant;
                    op_d      = sel_req;
                    id_d      = winner;
                    state_d   = ISSUE;
`ifdef ALU_SCHED_DIV0_EN
                    err_d     = 1'b0;
                    if (sel_req.op == DIV && sel_req.data2 == '0) begin
                        result_d = '1;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                lat_cnt_d = (op_q.op == ADD || op_q.op == SUB) ? LAT_W'(1)
                                                              : LAT_W'(MULDIV_CYCLES);
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    result_d = alu_result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == IDX_W'(NREQ - 1)) ? '0 : id_q + IDX_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            id_q      <= '0;
            rr_ptr_q  <= '0;
            lat_cnt_q <= '0;
            result_q  <= '0;
`ifdef ALU_SCHED_DIV0_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            id_q      <= id_d;
            rr_ptr_q  <= rr_ptr_d;
            lat_cnt_q <= lat_cnt_d;
            result_q  <= result_d;
`ifdef ALU_SCHED_DIV0_EN
            err_q     <= err_d;
`endif
        end
    end

    // Outputs are direct decodes of registered state.
    assign alu_start  = (state_q == ISSUE);
    assign alu_data1  = op_q.data1;
    assign alu_data2  = op_q.data2;
    assign alu_op     = op_q.op;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = result_q;
    assign rsp_id     = id_q;
    assign busy       = (state_q != IDLE);
`ifdef ALU_SCHED_DIV0_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched with a latency-accurate ALU model and
// a response scoreboard (expectations pushed at grant, popped at response).
module tb_alu_sched;

    localparam int NREQ   = 4;
    localparam int MULDIV = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*10-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 alu_start;
    logic [3:0]           alu_data1, alu_data2;
    logic [1:0]           alu_op;
    logic [8:0]           alu_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [8:0]           rsp_result;
    logic [1:0]           rsp_id;
    logic                 rsp_err;
    logic                 busy;

    typedef struct {
        int         id;
        logic [8:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];
    int   acc_log[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rsp_cnt = 0;
    int   alu_cnt;

    alu_sched #(.NREQ(NREQ), .MULDIV_CYCLES(MULDIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .alu_start  (alu_start),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] alu_calc(input logic [1:0] op, input logic [3:0] d1, input logic [3:0] d2);
        case (op)
            2'd0:    return 9'(d1) + 9'(d2);
            2'd1:    return 9'(d1) - 9'(d2);
            2'd2:    return 9'(d1) * 9'(d2);
            default: return (d2 == 4'd0) ? 9'h0FF : 9'(d1 / d2);
        endcase
    endfunction

    function automatic logic [8:0] exp_calc(input logic [1:0] op, input logic [3:0] d1, input logic [3:0] d2);
`ifdef ALU_SCHED_DIV0_EN
        if (op == 2'd3 && d2 == 4'd0) return 9'h1FF;
`endif
        return alu_calc(op, d1, d2);
    endfunction

    function automatic logic exp_err(input logic [1:0] op, input logic [3:0] d2);
`ifdef ALU_SCHED_DIV0_EN
        return (op == 2'd3 && d2 == 4'd0);
`else
        return 1'b0;
`endif
    endfunction

    // ALU model: result is only meaningful on the cycle the scheduler should capture it.
    always @(posedge clk or posedge reset) begin
        if (reset)            alu_cnt <= 0;
        else if (alu_start)   alu_cnt <= alu_op[1] ? MULDIV : 1;
        else if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
    end
    assign alu_result = (alu_cnt == 1) ? alu_calc(alu_op, alu_data1, alu_data2) : 9'h155;

    // Scoreboard monitor: push on grant handshake, pop on response handshake.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (req_ready != '0) begin
                logic [9:0] w;
                int         g;
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                total++;
                if ((req_ready & ~req_valid) != '0 || $countones(req_ready) != 1) begin
                    bad++;
                    $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
                end
                w = req_data[g*10 +: 10];
                sb.push_back('{g, exp_calc(w[9:8], w[3:0], w[7:4]), exp_err(w[9:8], w[7:4])});
                gnt_log.push_back(g);
                acc_log.push_back(cyc + 1);
            end
            if (rsp_valid && rsp_ready) begin
                exp_t e;
                total++;
                rsp_cnt++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: id=%0d result=%h with empty scoreboard", rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_result, rsp_err} !== {2'(e.id), e.res, e.err}) begin
                        bad++;
                        $display("FAIL rsp_data: got id=%0d res=%h err=%b, want id=%0d res=%h err=%b",
                                 rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        gnt_log.delete();
        acc_log.delete();
        reset = 1'b0;
    endtask

    // Drive one request and return the accept edge; drops valid after the handshake.
    task automatic send(input int id, input logic [1:0] op, input logic [3:0] d2,
                        input logic [3:0] d1, output int t);
        req_data[id*10 +: 10] = {op, d2, d1};
        req_valid[id] = 1'b1;
        t = -1;
        for (int k = 0; k < 50 && t < 0; k++) begin
            tick();
            if (req_ready[id]) begin
                t = cyc + 1;
                @(posedge clk);
                #1;
                req_valid[id] = 1'b0;
            end
        end
        if (t < 0) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: requester %0d never granted", id);
            req_valid[id] = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d responses outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        tick();
        total++;
        if ({req_ready, alu_start, alu_data1, alu_data2, alu_op} !== '0) begin
            bad++;
            $display("FAIL reset_alu: ready=%b start=%b d1=%h d2=%h op=%h, want all 0",
                     req_ready, alu_start, alu_data1, alu_data2, alu_op);
        end
        total++;
        if ({rsp_valid, rsp_result, rsp_id, rsp_err, busy} !== '0) begin
            bad++;
            $display("FAIL reset_rsp: valid=%b res=%h id=%h err=%b busy=%b, want all 0",
                     rsp_valid, rsp_result, rsp_id, rsp_err, busy);
        end
        do_reset();
    endtask

    task automatic test_add();
        int t;
        do_reset();
        send(0, 2'd0, 4'd5, 4'd3, t);
        tick();
        total++;
        if (alu_start !== 1'b1 || cyc != t) begin
            bad++;
            $display("FAIL add_start: alu_start=%b at cyc %0d, want 1 at cyc %0d", alu_start, cyc, t);
        end
        tick();
        total++;
        if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_wait: alu_start=%b rsp_valid=%b, want 0 0", alu_start, rsp_valid);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== 9'd8 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL add_rsp: valid=%b res=%0d id=%0d, want 1 8 0", rsp_valid, rsp_result, rsp_id);
        end
        drain("add");
    endtask

    task automatic test_mul();
        int t;
        do_reset();
        send(2, 2'd2, 4'd9, 4'd7, t);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL mul_busy: busy=%b in cycle T+%0d, want 1", busy, k + 1);
            end
            if (k == 3) begin
                total++;
                if (rsp_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL mul_early: rsp_valid=%b at T+4, want 0", rsp_valid);
                end
            end
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== 9'd63 || rsp_id !== 2'd2) begin
            bad++;
            $display("FAIL mul_rsp: valid=%b res=%0d id=%0d, want 1 63 2", rsp_valid, rsp_result, rsp_id);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mul_idle: busy=%b after response, want 0", busy);
        end
        drain("mul");
    endtask

    task automatic test_back_to_back();
        int want[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_data[0*10 +: 10] = {2'd0, 4'd2, 4'd1};
        req_data[1*10 +: 10] = {2'd1, 4'd6, 4'd4};
        req_data[2*10 +: 10] = {2'd2, 4'd15, 4'd15};
        req_data[3*10 +: 10] = {2'd3, 4'd4, 4'd14};
        req_valid = '1;
        for (int k = 0; k < 200 && gnt_log.size() < 5; k++) tick();
        req_valid = '0;
        total++;
        if (gnt_log.size() < 5) begin
            bad++;
            $display("FAIL rr_count: %0d grants seen, want 5", gnt_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (gnt_log[i] != want[i]) begin
                    bad++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, gnt_log[i], want[i]);
                end
            end
            total++;
            if (acc_log[1] - acc_log[0] != 4 || acc_log[3] - acc_log[2] != MULDIV + 3) begin
                bad++;
                $display("FAIL rr_spacing: add gap %0d mul gap %0d, want 4 %0d",
                         acc_log[1] - acc_log[0], acc_log[3] - acc_log[2], MULDIV + 3);
            end
        end
        drain("rr");
    endtask

    task automatic test_stall();
        int t;
        logic [8:0] r0;
        logic [1:0] i0;
        do_reset();
        rsp_ready = 1'b0;
        send(1, 2'd1, 4'd2, 4'd9, t);
        for (int k = 0; k < 20 && rsp_valid !== 1'b1; k++) tick();
        r0 = rsp_result;
        i0 = rsp_id;
        total++;
        if (rsp_valid !== 1'b1 || r0 !== 9'd7 || i0 !== 2'd1) begin
            bad++;
            $display("FAIL stall_rsp: valid=%b res=%0d id=%0d, want 1 7 1", rsp_valid, r0, i0);
        end
        req_data[3*10 +: 10] = {2'd0, 4'd1, 4'd1};
        req_valid[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (rsp_valid !== 1'b1 || rsp_result !== r0 || rsp_id !== i0 ||
                req_ready !== '0 || alu_start !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: valid=%b res=%h id=%0d ready=%b start=%b",
                         rsp_valid, rsp_result, rsp_id, req_ready, alu_start);
            end
        end
        req_valid[3] = 1'b0;
        rsp_ready = 1'b1;
        drain("stall");
    endtask

    task automatic test_reset_mid();
        int t;
        int cnt0;
        int seen;
        do_reset();
        send(3, 2'd3, 4'd3, 4'd9, t);
        tick();
        tick();
        cnt0 = rsp_cnt;
        reset = 1'b1;
        #1;
        sb.delete();
        total++;
        if ({busy, alu_start, rsp_valid, req_ready, alu_data1, alu_data2, alu_op, rsp_id, rsp_result, rsp_err} !== '0) begin
            bad++;
            $display("FAIL midreset_vals: busy=%b start=%b valid=%b d1=%h d2=%h op=%h id=%0d res=%h",
                     busy, alu_start, rsp_valid, alu_data1, alu_data2, alu_op, rsp_id, rsp_result);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || rsp_cnt != cnt0) begin
            bad++;
            $display("FAIL midreset_norsp: rsp_valid cycles=%0d responses=%0d, want 0 0", seen, rsp_cnt - cnt0);
        end
    endtask

    task automatic test_div0();
        int t;
        do_reset();
        send(1, 2'd3, 4'd0, 4'd9, t);
        tick();
        total++;
`ifdef ALU_SCHED_DIV0_EN
        if (alu_start !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 9'h1FF || rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL div0_short: start=%b valid=%b res=%h err=%b, want 0 1 1ff 1",
                     alu_start, rsp_valid, rsp_result, rsp_err);
        end
`else
        if (alu_start !== 1'b1 || alu_op !== 2'd3 || alu_data2 !== 4'd0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL div0_issue: start=%b op=%0d d2=%0d err=%b, want 1 3 0 0",
                     alu_start, alu_op, alu_data2, rsp_err);
        end
`endif
        drain("div0");
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_div0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
